// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared sizing constants and types for the register-file writeback scheduler.
package regfile_wb_scheduler_pkg;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  // Writeback port indices: port 0 is the ALU, port 1 the load unit.
  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;

  // One writeback request as seen after the port select.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   val;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the port that was not granted
// most recently wins; the pointer only moves when the caller reports that a
// grant actually turned into a transfer.
module rr_arb2
  import regfile_wb_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);
  // r_ptr = 0: port 0 wins a tie; r_ptr = 1: port 1 wins a tie.
  logic r_ptr;

  // One-hot grant: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_ptr ? 2'b10 : 2'b01;
    end
  end

  // After a transfer, favour the port that was just passed over.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_advance) begin
      r_ptr <= o_gnt[WB_ALU];
    end
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: arbitrates two writeback ports onto the
// single register bank write port and keeps a pending-write scoreboard that
// stalls issue on RAW/WAW hazards.
//
// Handshake (both writeback ports): a transfer happens in any cycle where
// wbK_valid && wbK_ready. While valid is high and ready is low the requester
// holds rd/val stable. ready is combinational, never high without valid, and
// at most one port is granted per cycle.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_valid,
  input  logic [REG_AW-1:0]   iss_rs1,
  input  logic [REG_AW-1:0]   iss_rs2,
  input  logic [REG_AW-1:0]   iss_rd,
  output logic                iss_stall,
  input  logic                wb0_valid,
  input  logic [REG_AW-1:0]   wb0_rd,
  input  logic [XLEN-1:0]     wb0_val,
  output logic                wb0_ready,
  input  logic                wb1_valid,
  input  logic [REG_AW-1:0]   wb1_rd,
  input  logic [XLEN-1:0]     wb1_val,
  output logic                wb1_ready,
  output logic                reg_we,
  output logic [REG_AW-1:0]   reg_rd,
  output logic [XLEN-1:0]     reg_val,
  output logic [NUM_REGS-1:0] pending,
  output logic                err_orphan
);
  logic [1:0]          w_gnt;
  logic                w_xfer;
  wb_req_t             w_sel;
  logic [NUM_REGS-1:0] w_pend_eff;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic                w_wr_real;
  logic                w_orphan;

  logic                r_reg_we;
  logic [REG_AW-1:0]   r_reg_rd;
  logic [XLEN-1:0]     r_reg_val;
  logic [NUM_REGS-1:0] r_pending;
  logic                r_err_orphan;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     ({wb1_valid, wb0_valid}),
    .i_advance (w_xfer),
    .o_gnt     (w_gnt)
  );

  // Grants are suppressed while reset is held so nothing transfers.
  assign wb0_ready = rst_n & w_gnt[WB_ALU];
  assign wb1_ready = rst_n & w_gnt[WB_LSU];
  assign w_xfer    = wb0_ready | wb1_ready;

  // x0 is never pending regardless of what the register holds.
  assign w_pend_eff = {r_pending[NUM_REGS-1:1], 1'b0};

  // Hazard check sees only this cycle's scoreboard: no bypass of a same-cycle clear.
  assign iss_stall = rst_n & iss_valid &
                     (w_pend_eff[iss_rs1] | w_pend_eff[iss_rs2] | w_pend_eff[iss_rd]);

  // Select the granted request and derive the scoreboard set/clear masks.
  always_comb begin
    w_sel.rd  = wb0_rd;
    w_sel.val = wb0_val;
    if (wb1_ready) begin
      w_sel.rd  = wb1_rd;
      w_sel.val = wb1_val;
    end
    w_wr_real = w_xfer && (w_sel.rd != '0);
    w_orphan  = w_wr_real && !w_pend_eff[w_sel.rd];
    w_set     = '0;
    w_clr     = '0;
    if (iss_valid && !iss_stall && (iss_rd != '0)) begin
      w_set[iss_rd] = 1'b1;
    end
    if (w_wr_real && w_pend_eff[w_sel.rd]) begin
      w_clr[w_sel.rd] = 1'b1;
    end
  end

  // Register bank write port: one-cycle pulse after a transfer, data held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reg_we  <= 1'b0;
      r_reg_rd  <= '0;
      r_reg_val <= '0;
    end else begin
      r_reg_we <= w_wr_real;
      if (w_wr_real) begin
        r_reg_rd  <= w_sel.rd;
        r_reg_val <= w_sel.val;
      end
    end
  end

  // Scoreboard update and sticky orphan-writeback flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending    <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_pending <= (r_pending | w_set) & ~w_clr;
      if (w_orphan) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  assign reg_we     = r_reg_we;
  assign reg_rd     = r_reg_rd;
  assign reg_val    = r_reg_val;
  assign pending    = r_pending;
  assign err_orphan = r_err_orphan;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: a table of per-cycle input records with
// hand-derived combinational expectations, a reference model that predicts
// the registered outputs into an expected queue, and a contention sequence.
module tb_regfile_wb_scheduler;
  logic        clk;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_stall;
  logic        wb0_valid, wb0_ready;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_val;
  logic        wb1_valid, wb1_ready;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_val;
  logic        reg_we;
  logic [4:0]  reg_rd;
  logic [31:0] reg_val;
  logic [31:0] pending;
  logic        err_orphan;

  regfile_wb_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_stall(iss_stall),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_val(wb0_val), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_val(wb1_val), .wb1_ready(wb1_ready),
    .reg_we(reg_we), .reg_rd(reg_rd), .reg_val(reg_val),
    .pending(pending), .err_orphan(err_orphan)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- records ----------------
  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic        w0v;
    logic [4:0]  w0rd;
    logic [31:0] w0val;
    logic        w1v;
    logic [4:0]  w1rd;
    logic [31:0] w1val;
    logic        e_st, e_r0, e_r1;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic iv, input logic [4:0] rs1, rs2, rd,
                              input logic w0v, input logic [4:0] w0rd, input logic [31:0] w0val,
                              input logic w1v, input logic [4:0] w1rd, input logic [31:0] w1val,
                              input logic est, input logic er0, input logic er1);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.w0v = w0v; v.w0rd = w0rd; v.w0val = w0val;
    v.w1v = w1v; v.w1rd = w1rd; v.w1val = w1val;
    v.e_st = est; v.e_r0 = er0; v.e_r1 = er1;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [38:0] exp_q[$];     // {check_data, we, rd, val}
  logic [32:0] exp_st_q[$];  // {err_orphan, pending}

  logic [31:0] m_pending;
  logic        m_ptr;
  logic        m_orphan;
  logic [4:0]  m_rd;
  logic [31:0] m_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference prediction of the combinational outputs for a record.
  task automatic model_comb(input vec_t v, output logic st, output logic g0, output logic g1);
    logic [31:0] pe;
    pe = m_pending & ~32'h1;
    if (!v.rst_n) begin
      st = 1'b0; g0 = 1'b0; g1 = 1'b0;
    end else begin
      st = v.iv && (pe[v.rs1] || pe[v.rs2] || pe[v.rd]);
      if (v.w0v && v.w1v) begin
        g0 = !m_ptr; g1 = m_ptr;
      end else begin
        g0 = v.w0v; g1 = v.w1v;
      end
    end
  endtask

  // Drive one cycle, check combinational outputs, predict and check registered ones.
  task automatic run_cycle(input vec_t v, input string tag);
    logic st, g0, g1;
    logic [4:0]  wrd;
    logic [31:0] wval, pe, set_m, clr_m;
    logic [38:0] e;
    logic [32:0] es;
    rst_n = v.rst_n; iss_valid = v.iv; iss_rs1 = v.rs1; iss_rs2 = v.rs2; iss_rd = v.rd;
    wb0_valid = v.w0v; wb0_rd = v.w0rd; wb0_val = v.w0val;
    wb1_valid = v.w1v; wb1_rd = v.w1rd; wb1_val = v.w1val;
    #1;
    check({tag, " iss_stall"}, {31'd0, iss_stall}, {31'd0, v.e_st});
    check({tag, " wb0_ready"}, {31'd0, wb0_ready}, {31'd0, v.e_r0});
    check({tag, " wb1_ready"}, {31'd0, wb1_ready}, {31'd0, v.e_r1});
    check({tag, " ready_excl"}, {31'd0, wb0_ready & wb1_ready}, 32'd0);
    model_comb(v, st, g0, g1);
    if (!v.rst_n) begin
      m_pending = '0; m_ptr = 1'b0; m_orphan = 1'b0; m_rd = '0; m_val = '0;
      e = {1'b1, 1'b0, 5'd0, 32'd0};
    end else begin
      pe = m_pending & ~32'h1;
      set_m = '0; clr_m = '0;
      if (v.iv && !st && v.rd != 5'd0) set_m[v.rd] = 1'b1;
      wrd  = g1 ? v.w1rd : v.w0rd;
      wval = g1 ? v.w1val : v.w0val;
      if ((g0 || g1) && wrd != 5'd0) begin
        if (pe[wrd]) clr_m[wrd] = 1'b1;
        else m_orphan = 1'b1;
        m_rd = wrd; m_val = wval;
        e = {1'b1, 1'b1, wrd, wval};
      end else if (g0 || g1) begin
        e = {1'b0, 1'b0, m_rd, m_val};
      end else begin
        e = {1'b1, 1'b0, m_rd, m_val};
      end
      m_pending = (m_pending | set_m) & ~clr_m;
      if (g0) m_ptr = 1'b1;
      else if (g1) m_ptr = 1'b0;
    end
    exp_q.push_back(e);
    exp_st_q.push_back({m_orphan, m_pending});
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    es = exp_st_q.pop_front();
    check({tag, " reg_we"}, {31'd0, reg_we}, {31'd0, e[37]});
    if (e[38]) begin
      check({tag, " reg_rd"}, {27'd0, reg_rd}, {27'd0, e[36:32]});
      check({tag, " reg_val"}, reg_val, e[31:0]);
    end
    check({tag, " pending"}, pending, es[31:0]);
    check({tag, " err_orphan"}, {31'd0, err_orphan}, {31'd0, es[32]});
  endtask

  // ---------------- test ----------------
  vec_t tbl[22];
  vec_t v;
  logic st, g0, g1;
  int   idx0, idx1;
  logic [31:0] cv0, cv1;

  initial begin
    m_pending = '0; m_ptr = 1'b0; m_orphan = 1'b0; m_rd = '0; m_val = '0;
    rst_n = 1'b0; iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    wb0_valid = 1'b0; wb0_rd = '0; wb0_val = '0;
    wb1_valid = 1'b0; wb1_rd = '0; wb1_val = '0;

    //           rst iv rs1 rs2 rd   w0v w0rd w0val          w1v w1rd w1val          st r0 r1
    tbl[0]  = mk(1, 1, 0, 0, 5,     0, 0, 32'h0,           0, 0, 32'h0,           0, 0, 0);
    tbl[1]  = mk(1, 1, 5, 0, 6,     0, 0, 32'h0,           0, 0, 32'h0,           1, 0, 0);
    tbl[2]  = mk(1, 1, 5, 0, 6,     1, 5, 32'hDEADBEEF,    0, 0, 32'h0,           1, 1, 0);
    tbl[3]  = mk(1, 1, 5, 0, 6,     0, 0, 32'h0,           0, 0, 32'h0,           0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0,     0, 0, 32'h0,           1, 6, 32'h00000066,    0, 0, 1);
    tbl[5]  = mk(1, 1, 0, 0, 1,     0, 0, 32'h0,           0, 0, 32'h0,           0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0, 2,     0, 0, 32'h0,           0, 0, 32'h0,           0, 0, 0);
    tbl[7]  = mk(1, 1, 0, 0, 3,     0, 0, 32'h0,           0, 0, 32'h0,           0, 0, 0);
    tbl[8]  = mk(1, 1, 0, 0, 4,     0, 0, 32'h0,           0, 0, 32'h0,           0, 0, 0);
    tbl[9]  = mk(1, 1, 0, 4, 9,     0, 0, 32'h0,           0, 0, 32'h0,           1, 0, 0);
    tbl[10] = mk(1, 1, 0, 0, 4,     0, 0, 32'h0,           0, 0, 32'h0,           1, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0,     1, 1, 32'hA1A1A1A1,    1, 2, 32'hB2B2B2B2,    0, 1, 0);
    tbl[12] = mk(1, 0, 0, 0, 0,     1, 3, 32'hA3A3A3A3,    1, 2, 32'hB2B2B2B2,    0, 0, 1);
    tbl[13] = mk(1, 0, 0, 0, 0,     1, 3, 32'hA3A3A3A3,    0, 0, 32'h0,           0, 1, 0);
    tbl[14] = mk(1, 0, 0, 0, 0,     0, 0, 32'h0,           1, 0, 32'h12345678,    0, 0, 1);
    tbl[15] = mk(1, 0, 0, 0, 0,     1, 7, 32'h77777777,    0, 0, 32'h0,           0, 1, 0);
    tbl[16] = mk(1, 1, 0, 0, 3,     0, 0, 32'h0,           1, 4, 32'h44444444,    0, 0, 1);
    tbl[17] = mk(1, 0, 0, 0, 0,     1, 0, 32'h0,           0, 0, 32'h0,           0, 1, 0);
    tbl[18] = mk(0, 1, 3, 0, 8,     1, 3, 32'h33333333,    0, 0, 32'h0,           0, 0, 0);
    tbl[19] = mk(1, 0, 0, 0, 0,     0, 0, 32'h0,           0, 0, 32'h0,           0, 0, 0);
    tbl[20] = mk(1, 0, 0, 0, 0,     1, 0, 32'h00000001,    1, 0, 32'h00000002,    0, 1, 0);
    tbl[21] = mk(1, 0, 0, 0, 0,     1, 0, 32'h00000003,    1, 0, 32'h00000004,    0, 0, 1);

    // Hand sequence: reset held two cycles with a request waiting, then idle.
    run_cycle(mk(0, 1, 1, 2, 3, 1, 5, 32'h55, 1, 6, 32'h66, 0, 0, 0), "rst0");
    run_cycle(mk(0, 1, 1, 2, 3, 1, 5, 32'h55, 1, 6, 32'h66, 0, 0, 0), "rst1");
    run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0), "idle");

    for (int i = 0; i < 22; i++) begin
      run_cycle(tbl[i], $sformatf("vec%0d", i));
    end

    // Hand sequence: fill x10..x15, then drain through both ports under contention.
    for (int r = 10; r < 16; r++) begin
      v = mk(1, 1, 0, 0, 5'(r), 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
      model_comb(v, st, g0, g1);
      v.e_st = st; v.e_r0 = g0; v.e_r1 = g1;
      run_cycle(v, $sformatf("fill%0d", r));
    end
    idx0 = 0; idx1 = 0;
    cv0 = $urandom_range(32'h7FFFFFFF, 1);
    cv1 = $urandom_range(32'h7FFFFFFF, 1);
    for (int c = 0; c < 10; c++) begin
      if (idx0 < 3 || idx1 < 3) begin
        v = mk(1, 0, 0, 0, 0,
               (idx0 < 3), 5'(10 + 2 * idx0), cv0,
               (idx1 < 3), 5'(11 + 2 * idx1), cv1, 0, 0, 0);
        model_comb(v, st, g0, g1);
        v.e_st = st; v.e_r0 = g0; v.e_r1 = g1;
        run_cycle(v, $sformatf("drain%0d", c));
        if (g0) begin idx0++; cv0 = $urandom_range(32'h7FFFFFFF, 1); end
        if (g1) begin idx1++; cv1 = $urandom_range(32'h7FFFFFFF, 1); end
      end
    end
    check("drain_done0", idx0, 3);
    check("drain_done1", idx1, 3);
    run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0), "final_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 SHALL have ports, one per line, as follows (clock and reset first).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 iss_valid  in  1  issue stage presents an instruction.
REQ-005 iss_rs1, iss_rs2  in  5 each  source register addresses of issuing instruction.
REQ-006 iss_rd  in  5  destination address of issuing instruction.
REQ-007 iss_stall  out  1  combinational; hazard, issue must hold.
REQ-008 wb0_valid, wb0_rd, wb0_val  in  1/5/32  ALU writeback request.
REQ-009 wb0_ready  out  1  combinational grant to port 0.
REQ-010 wb1_valid, wb1_rd, wb1_val  in  1/5/32  load-unit writeback request.
REQ-011 wb1_ready  out  1  combinational grant to port 1.
REQ-012 reg_we, reg_rd, reg_val  out  1/5/32  registered drive of register bank write port.
REQ-013 pending  out  32  registered scoreboard, bit n = write to xn outstanding.
REQ-014 err_orphan  out  1  sticky; writeback seen for non-pending register.

Function
REQ-015 Handshake: transfer on port k when wbk_valid && wbk_ready; requester holds rd/val stable while valid && !ready.
REQ-016 Arbitration: at most one of wb0_ready/wb1_ready high per cycle; ready never asserted without matching valid.
REQ-017 Single requester valid: that port granted same cycle.
REQ-018 Both valid: round-robin; port not granted most recently wins; pointer updates only on a transfer.
REQ-019 Latency: transfer in cycle N -> reg_we=1, reg_rd, reg_val valid in cycle N+1, for exactly one cycle.
REQ-020 No transfer in cycle N -> reg_we=0 in cycle N+1; reg_rd/reg_val hold previous values.
REQ-021 Transfer with rd=0: accepted (ready asserted), reg_we=0 next cycle, no scoreboard change.
REQ-022 iss_stall = iss_valid && (pending[iss_rs1] || pending[iss_rs2] || pending[iss_rd]), bit 0 treated as never pending.
REQ-023 Issue accept: iss_valid && !iss_stall && iss_rd!=0 -> pending[iss_rd] set next cycle.
REQ-024 Writeback transfer with rd=r, r!=0, pending[r]=1 -> pending[r] cleared next cycle.
REQ-025 Writeback transfer with rd=r, r!=0, pending[r]=0 -> write still performed, err_orphan set, held until reset.
REQ-026 Stall uses current-cycle pending only; a clear in same cycle does not release stall (no bypass).
REQ-027 Simultaneous issue set of register a and writeback clear of register b, a!=b: both take effect.
REQ-028 Same-register set and clear in one cycle is impossible by REQ-022; no priority logic required.
REQ-029 No throttling of issue other than iss_stall; scheduler holds no data buffer.

Reset
REQ-030 rst_n=0 at a rising edge: pending=0, reg_we=0, reg_rd=0, reg_val=0, err_orphan=0, round-robin pointer favours port 0.
REQ-031 During reset, wb0_ready=wb1_ready=0 and iss_stall=0; no transfer counted.
REQ-032 Reset mid-transfer: in-flight write discarded, reg_we=0 in cycle after reset.

Structure
REQ-033 Shared package SHALL hold XLEN=32, NUM_REGS=32, REG_AW=5, port index constants WB_ALU=0, WB_LSU=1.
REQ-034 Arbitration SHALL be a sub-module rr_arb2 (two requests, two one-hot grants, advance input, pointer register).
REQ-035 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-036 Reset, then idle: pending=0, reg_we=0, err_orphan=0, both ready=0.
REQ-037 Issue rd=5, then rs1=5 issue -> iss_stall=1; wb0 rd=5 val=0xDEADBEEF -> next cycle reg_we=1, reg_rd=5, reg_val=0xDEADBEEF, pending[5]=0; stall drops following cycle.
REQ-038 wb0 and wb1 valid continuously (rd=1,2, both pending) -> grants alternate 0,1; reg_rd sequence 1,2; wb0_ready never high with wb1_ready.
REQ-039 wb1 transfer rd=0 val=0x12345678 -> wb1_ready=1, reg_we=0 next cycle, pending unchanged.
REQ-040 wb0 transfer rd=7 with pending[7]=0 -> reg_we=1 rd=7, err_orphan=1 and stays 1 until rst_n=0.
REQ-041 Issue rd=3 with simultaneous wb1 transfer rd=4 (pending[4]=1), then rst_n=0 during a new transfer -> pending[3]=1, pending[4]=0, then after reset all outputs zero.
